calc3_req_master: RTL
=====================

# calc3_req_master

Per-port requester for the CALC-3 calculator request/response interface. Accepts calculation jobs through a valid/ready handshake, assigns a free 2-bit tag, drives one `req*_` command cycle into a CALC-3 port, tracks up to four outstanding tags, and matches `out*_` responses back to their tags as completion records. One instance sits in front of each of the four CALC-3 ports. It is the synthesizable initiator that replaces hand-sequenced bench stimulus.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: cycles after issue before an unanswered tag is force-completed. Legal range 2..1023.

Ports:
- `c_clk` input, 1: single clock, rising-edge.
- `reset_n` input, 1: asynchronous, active-low reset.
- `job_valid` input, 1: job offered.
- `job_ready` output, 1: job accepted when `job_valid && job_ready` at a rising edge.
- `job_cmd` input, [0:3]: CALC-3 command code.
- `job_d1`, `job_d2`, `job_r1` input, [0:3]: register operands.
- `job_data` input, [0:31]: store data.
- `req_cmd` output, [0:3]: to the DUT `reqN_cmd`.
- `req_d1`, `req_d2`, `req_r1` output, [0:3]: to the DUT operands.
- `req_data` output, [0:31]: to the DUT `reqN_data`.
- `req_tag` output, [0:1]: to the DUT `reqN_tag`.
- `out_resp` input, [0:1]: from the DUT. 0 means idle, 1 success, 2 overflow/underflow, 3 invalid.
- `out_data` input, [0:31]: response data.
- `out_tag` input, [0:1]: response tag.
- `cpl_valid` output, 1: one-cycle completion pulse. There is no backpressure on this output.
- `cpl_tag` output, [0:1]: tag of the completed request.
- `cpl_cmd` output, [0:3]: original command for that tag.
- `cpl_resp` output, [0:1]: response code. Value 0 means timeout.
- `cpl_data` output, [0:31]: response data. Value 0 on timeout.
- `err_spurious` output, 1: one-cycle pulse when a response arrives for a non-outstanding tag.

## Operation
- **State per tag (0..3):**
  - busy bit;
  - stored `cmd`;
  - age counter, ceil(log2(TIMEOUT_CYCLES+1)) bits.
- **Readiness:** `job_ready` = any busy bit clear. It is combinational from registered state only; it does not depend on `job_valid`.
- **Tag allocation:** the lowest-numbered free tag.
- **On acceptance, at the same edge:**
  - set busy;
  - store `job_cmd`;
  - clear the age counter;
  - register all `job_*` fields onto `req_*` with `req_tag` = the allocated tag.
- **Idle drive:** in every cycle without acceptance, `req_cmd` = 0 and `req_d1`/`req_d2`/`req_r1`/`req_data`/`req_tag` = 0. Each request is therefore exactly one cycle wide.
- **Response sampling:** each edge with `out_resp != 0`:
  - if `busy[out_tag]`, then clear busy and register a completion `{out_tag, cmd[out_tag], out_resp, out_data}`;
  - otherwise, pulse `err_spurious`, produce no completion, and change no state.
- **Age counting:** the counter of each busy tag increments each cycle and saturates at `TIMEOUT_CYCLES`.
- **Timeout completion:** a tag whose age equals `TIMEOUT_CYCLES` is completed with `cpl_resp` = 0 and `cpl_data` = 0, and its busy bit is cleared. This path exists only with the timeout feature.
- **Arbitration per edge:** at most one completion.
  - A valid response wins.
  - Otherwise, the lowest-numbered expired tag completes.
  - Other expired tags wait, with their counters held saturated.
- **Same-tag collision:** a response and a timeout on the same tag in the same cycle produce the response completion only.
- **Jobs with `job_cmd` = 0 (no-op):** still accepted and tagged. They complete only by timeout, or are held forever if the timeout feature is compiled out. Upstream must not send them.

## Timing
- **Reset (asynchronous assert, synchronous deassert by the system):**
  - all `req_*` outputs = 0;
  - `cpl_valid` = 0 and all `cpl_*` outputs = 0;
  - `err_spurious` = 0;
  - `job_ready` = 0 while `reset_n` is low;
  - all busy bits and age counters clear.
- **After reset release:** `job_ready` = 1.
- **Issue latency:** a job accepted at edge N has `req_*` valid in cycle N..N+1, i.e. visible at the DUT's sampling edge N+1.
- **Completion latency:** a response sampled at edge M gives `cpl_valid` high in cycle M..M+1.
- **Tag reuse:** a tag freed at edge M is allocatable from the next cycle, via `job_ready`. Back-to-back accept at M+1 is legal.
- **Full condition:** with all four tags busy, `job_ready` = 0. An accept and a free in the same edge do not chain.
- **Reset mid-operation:**
  - all outstanding tags are dropped without a completion;
  - any `req_cmd` being driven is forced to 0 immediately (asynchronously).

## Configuration
- **`CALC3_MASTER_TIMEOUT_EN` defined:** age counters and the timeout completion path are present, as described above.
- **Not defined:**
  - no counters are present;
  - tags stay busy until answered;
  - `cpl_resp` is never 0;
  - `TIMEOUT_CYCLES` is ignored.

## Test plan
- **Reset then single add.**
  - Stimulus: job cmd=1, d1=1, d2=1, r1=2. Bench responder returns resp=1, data=0x2 three cycles after issue.
  - Required: `req_cmd`=1 and `req_tag`=0 for exactly one cycle, then `cpl_valid` with tag=0, cmd=1, resp=1, data=0x00000002.
- **Fill all tags.**
  - Stimulus: four store jobs (cmd=9, r1=1, data=0x1..0x4) with no responses.
  - Required: tags 0, 1, 2, 3 in order. `job_ready`=0 after the fourth. A fifth `job_valid` is stalled until the tag 2 response, then issued with tag 2.
- **Out-of-order responses.**
  - Stimulus: responses for tags 3, 0, 2, 1.
  - Required: completions in that order, each carrying its stored cmd.
- **Spurious response.**
  - Stimulus: resp=1 with tag=1 while idle.
  - Required: `err_spurious` pulses once, no `cpl_valid`, `job_ready` stays 1.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=8).**
  - Stimulus: cmd=10 with no response.
  - Required: `cpl_valid` with resp=0 and data=0 eight cycles after issue. Tag 0 is reusable the next cycle. A response for tag 0 in the same cycle as expiry yields only the response completion.
- **Reset mid-flight.**
  - Stimulus: assert `reset_n` low while two tags are busy and `req_cmd`=1.
  - Required: `req_cmd`=0 immediately. After release, `job_ready`=1, there are no completions, and the next job gets tag 0.

Source files
------------

// File: rtl/calc3_req_master.sv
`default_nettype none
// ============================================================================
// calc3_req_master : tagged CALC-3 port requester with completion matching.
// Optional macro CALC3_MASTER_TIMEOUT_EN adds per-tag age timeout.
// Revision: 1.0
// ============================================================================
module calc3_req_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        c_clk,
  input  logic        reset_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [0:3]  job_cmd,
  input  logic [0:3]  job_d1,
  input  logic [0:3]  job_d2,
  input  logic [0:3]  job_r1,
  input  logic [0:31] job_data,
  output logic [0:3]  req_cmd,
  output logic [0:3]  req_d1,
  output logic [0:3]  req_d2,
  output logic [0:3]  req_r1,
  output logic [0:31] req_data,
  output logic [0:1]  req_tag,
  input  logic [0:1]  out_resp,
  input  logic [0:31] out_data,
  input  logic [0:1]  out_tag,
  output logic        cpl_valid,
  output logic [0:1]  cpl_tag,
  output logic [0:3]  cpl_cmd,
  output logic [0:1]  cpl_resp,
  output logic [0:31] cpl_data,
  output logic        err_spurious
);

  logic [3:0]  busy_q, busy_d;
  logic [0:3]  cmd_q [4];
  logic [0:3]  cmd_d [4];
  logic        ready_en_q;
  logic [0:3]  req_cmd_q, req_cmd_d, req_d1_q, req_d1_d, req_d2_q, req_d2_d, req_r1_q, req_r1_d;
  logic [0:31] req_data_q, req_data_d;
  logic [0:1]  req_tag_q, req_tag_d;
  logic        cpl_valid_q, cpl_valid_d;
  logic [0:1]  cpl_tag_q, cpl_tag_d;
  logic [0:3]  cpl_cmd_q, cpl_cmd_d;
  logic [0:1]  cpl_resp_q, cpl_resp_d;
  logic [0:31] cpl_data_q, cpl_data_d;
  logic        err_spurious_q, err_spurious_d;

  logic        accept;
  logic [1:0]  alloc_tag;
  logic        resp_v, resp_hit;
  logic        to_valid;
  logic [1:0]  to_tag;
  logic [1:0]  sel_tag;

  // ready_en_q keeps job_ready low throughout reset without a combinational path from reset_n
  assign job_ready = ready_en_q & ~(&busy_q);
  assign accept    = job_valid & job_ready;
  assign resp_v    = |out_resp;
  assign resp_hit  = resp_v & busy_q[out_tag];

  always_comb begin
    alloc_tag = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!busy_q[i]) alloc_tag = 2'(i);
    end
  end

`ifdef CALC3_MASTER_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYCLES);

  logic [AGE_W-1:0] age_q [4];
  logic [AGE_W-1:0] age_d [4];
  logic [3:0]       expired;

  always_comb begin
    to_tag = 2'd0;
    for (int i = 0; i < 4; i++) begin
      expired[i] = busy_q[i] && (age_q[i] == AGE_MAX);
    end
    for (int i = 3; i >= 0; i--) begin
      if (expired[i]) to_tag = 2'(i);
    end
    to_valid = (|expired) & ~resp_hit;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      age_d[i] = age_q[i];
      if (accept && (alloc_tag == 2'(i))) age_d[i] = '0;
      else if (busy_q[i] && (age_q[i] != AGE_MAX)) age_d[i] = age_q[i] + AGE_W'(1);
    end
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) age_q[i] <= age_d[i];
    end
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES > 0);
  assign to_valid = 1'b0;
  assign to_tag   = 2'd0;
`endif

  assign sel_tag = resp_hit ? out_tag : to_tag;

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < 4; i++) cmd_d[i] = cmd_q[i];
    if (accept) begin
      busy_d[alloc_tag] = 1'b1;
      cmd_d[alloc_tag]  = job_cmd;
    end
    // accept only targets free tags, completion only busy ones, so the two never collide
    if (resp_hit || to_valid) busy_d[sel_tag] = 1'b0;

    req_cmd_d  = accept ? job_cmd   : '0;
    req_d1_d   = accept ? job_d1    : '0;
    req_d2_d   = accept ? job_d2    : '0;
    req_r1_d   = accept ? job_r1    : '0;
    req_data_d = accept ? job_data  : '0;
    req_tag_d  = accept ? alloc_tag : '0;

    cpl_valid_d    = resp_hit | to_valid;
    cpl_tag_d      = cpl_valid_d ? sel_tag : '0;
    cpl_cmd_d      = cpl_valid_d ? cmd_q[sel_tag] : '0;
    cpl_resp_d     = resp_hit ? out_resp : '0;
    cpl_data_d     = resp_hit ? out_data : '0;
    err_spurious_d = resp_v & ~resp_hit;
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q         <= '0;
      for (int i = 0; i < 4; i++) cmd_q[i] <= '0;
      ready_en_q     <= 1'b0;
      req_cmd_q      <= '0;
      req_d1_q       <= '0;
      req_d2_q       <= '0;
      req_r1_q       <= '0;
      req_data_q     <= '0;
      req_tag_q      <= '0;
      cpl_valid_q    <= 1'b0;
      cpl_tag_q      <= '0;
      cpl_cmd_q      <= '0;
      cpl_resp_q     <= '0;
      cpl_data_q     <= '0;
      err_spurious_q <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      for (int i = 0; i < 4; i++) cmd_q[i] <= cmd_d[i];
      ready_en_q     <= 1'b1;
      req_cmd_q      <= req_cmd_d;
      req_d1_q       <= req_d1_d;
      req_d2_q       <= req_d2_d;
      req_r1_q       <= req_r1_d;
      req_data_q     <= req_data_d;
      req_tag_q      <= req_tag_d;
      cpl_valid_q    <= cpl_valid_d;
      cpl_tag_q      <= cpl_tag_d;
      cpl_cmd_q      <= cpl_cmd_d;
      cpl_resp_q     <= cpl_resp_d;
      cpl_data_q     <= cpl_data_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  assign req_cmd      = req_cmd_q;
  assign req_d1       = req_d1_q;
  assign req_d2       = req_d2_q;
  assign req_r1       = req_r1_q;
  assign req_data     = req_data_q;
  assign req_tag      = req_tag_q;
  assign cpl_valid    = cpl_valid_q;
  assign cpl_tag      = cpl_tag_q;
  assign cpl_cmd      = cpl_cmd_q;
  assign cpl_resp     = cpl_resp_q;
  assign cpl_data     = cpl_data_q;
  assign err_spurious = err_spurious_q;

endmodule
`default_nettype wire
